// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the round-robin mux arbiter slice.
//   arb_state_t : FSM encoding (IDLE, GRANT)
//   NUM_CH      : number of arbitrated channels (4)
//   IDX_W       : width of a channel index (2)
//   ch_onehot   : converts a channel index into a one-hot channel mask
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot mask for a channel index, used for gnt
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CH-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick
// Wrap-around priority search: returns the first requesting channel found
// when scanning upward from ptr (3 wraps to 0).
// Ports:
//   req    in  4  per-channel request mask
//   ptr    in  2  channel index the search starts from
//   winner out 2  index of the first requester found (0 when none)
//   any    out 1  at least one request bit is set
import mux_arb_pkg::*;

module mux_rr_pick (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              any
);

  logic [IDX_W-1:0] idx;

  // Scan ptr, ptr+1, ... with natural 2-bit wrap; the first hit wins
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter for four single-bit channels feeding an external 4:1
// mux. A grant holds for BURST transfers (or until its requester drops),
// then rotates to the next requester. Outputs are fully registered.
// Parameters:
//   BURST      transfers per grant before rotating (1..15)
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   req        in  4  per-channel request (bit0=a .. bit3=d)
//   data       in  4  per-channel data bit
//   lock       in  4  per-channel grant lock (only honoured with the macro)
//   out_ready  in  1  downstream accepts the current transfer
//   out_valid  out 1  sel/gnt/y hold a valid transfer
//   sel        out 2  granted channel index (downstream mux select)
//   gnt        out 4  one-hot grant, zero when idle
//   y          out 1  registered data bit of the granted channel
// Configuration:
//   MUX_ARB_LOCK_EN  when defined, lock[sel] with req[sel] keeps the grant
//                    regardless of BURST and clears the transfer counter.
import mux_arb_pkg::*;

module mux_rr_arbiter #(
  parameter int BURST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] data,
  input  logic [NUM_CH-1:0] lock,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  sel,
  output logic [NUM_CH-1:0] gnt,
  output logic              y
);

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] ptr;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_any;
  logic             xfer;
  logic             hold_lock;
  logic             rotate;
  logic             load_grant;
  logic             keep_grant;

  // ptr always sits one past the current/last grant, so searching from it
  // naturally puts sel last: sel only wins again if it is the sole requester.
  mux_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

`ifdef MUX_ARB_LOCK_EN
  // A locked, still-requesting channel keeps the grant
  assign hold_lock = lock[sel] & req[sel];
`else
  logic lock_unused;
  assign lock_unused = ^lock;
  assign hold_lock   = 1'b0;
`endif

  assign xfer   = (state == GRANT) && out_ready;
  assign rotate = ((cnt == BURST_LAST) || !req[sel]) && !hold_lock;

  // Grant loads on entry from IDLE and on a rotating transfer with a
  // requester available; otherwise a non-rotating transfer just refreshes y.
  always_comb begin
    load_grant = 1'b0;
    keep_grant = 1'b0;
    if (state == IDLE) begin
      load_grant = pick_any;
    end else if (xfer) begin
      load_grant = rotate && pick_any;
      keep_grant = !rotate;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave GRANT only when rotating with nobody requesting
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = GRANT;
      GRANT:   if (xfer && rotate && !pick_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: validity and grant follow the state; gnt mirrors sel
  always_comb begin
    out_valid = (state == GRANT);
    gnt       = out_valid ? ch_onehot(sel) : '0;
  end

  // Datapath: sel, y, ptr and the burst counter only move on a new grant or
  // an accepted transfer, so everything holds during a stall. sel keeps its
  // last value when the arbiter drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
      y   <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else if (load_grant) begin
      sel <= pick_winner;
      y   <= data[pick_winner];
      ptr <= pick_winner + IDX_W'(1);
      cnt <= '0;
    end else if (keep_grant) begin
      y   <= data[sel];
      cnt <= hold_lock ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Directed bench for mux_rr_arbiter. Two instances share the inputs:
// dut1 with BURST=1 and dut2 with BURST=2. Inputs change 1 time unit after
// a rising edge and outputs are checked at that same point.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] lock;
  logic       out_ready;

  logic       ov1, ov2;
  logic [1:0] sel1, sel2;
  logic [3:0] gnt1, gnt2;
  logic       y1, y2;

  int checks;
  int fails;

  mux_rr_arbiter #(.BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .lock(lock),
    .out_ready(out_ready), .out_valid(ov1), .sel(sel1), .gnt(gnt1), .y(y1)
  );

  mux_rr_arbiter #(.BURST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .lock(lock),
    .out_ready(out_ready), .out_valid(ov2), .sel(sel2), .gnt(gnt2), .y(y2)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive a new input vector
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                               input logic [3:0] l, input logic rdy);
    req       = r;
    data      = d;
    lock      = l;
    out_ready = rdy;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances with idle inputs
  task automatic doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_seq[5];
  logic [1:0] lock_seq[4];

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    #2;

    // Reset state
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {3'b0, ov1}, 4'b0000);
    checkOutput("rst_gnt", gnt1, 4'b0000);
    checkOutput("rst_sel", {2'b0, sel1}, 4'b0000);
    checkOutput("rst_y", {3'b0, y1}, 4'b0000);
    tick();
    rst_n = 1'b1;

    // Single requester: one-cycle latency, then back to IDLE once req drops
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
    #1;
    checkOutput("single_no_comb", {3'b0, ov1}, 4'b0000);
    tick();
    checkOutput("single_valid", {3'b0, ov1}, 4'b0001);
    checkOutput("single_sel", {2'b0, sel1}, 4'b0000);
    checkOutput("single_gnt", gnt1, 4'b0001);
    checkOutput("single_y", {3'b0, y1}, 4'b0001);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 1'b1);
    tick();
    checkOutput("single_idle_valid", {3'b0, ov1}, 4'b0000);
    checkOutput("single_idle_gnt", gnt1, 4'b0000);
    checkOutput("single_idle_sel", {2'b0, sel1}, 4'b0000);

    // BURST=1, all requesting: strict rotation with no bubble
    doReset();
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    applyStimulus(4'b1111, 4'b1010, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("rr_sel%0d", i), {2'b0, sel1}, {2'b0, exp_seq[i]});
      checkOutput($sformatf("rr_valid%0d", i), {3'b0, ov1}, 4'b0001);
      checkOutput($sformatf("rr_y%0d", i), {3'b0, y1}, {3'b0, exp_seq[i][0]});
    end

    // Stall on channel 2 while req/data toggle, then one accepted transfer
    doReset();
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
    tick();
    checkOutput("stall_entry_sel", {2'b0, sel1}, 4'b0010);
    checkOutput("stall_entry_y", {3'b0, y1}, 4'b0001);
    applyStimulus(4'b1011, 4'b0000, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b1011, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b1111, 4'b0011, 4'b0000, 1'b0);
    tick();
    checkOutput("stall_sel", {2'b0, sel1}, 4'b0010);
    checkOutput("stall_gnt", gnt1, 4'b0100);
    checkOutput("stall_y", {3'b0, y1}, 4'b0001);
    checkOutput("stall_valid", {3'b0, ov1}, 4'b0001);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
    checkOutput("stall_xfer_sel", {2'b0, sel1}, 4'b0010);
    checkOutput("stall_xfer_y", {3'b0, y1}, 4'b0000);
    checkOutput("stall_xfer_y_b2", {3'b0, y2}, 4'b0000);
    tick();
    checkOutput("stall_after_y", {3'b0, y1}, 4'b0000);

    // BURST=2 on dut2: two transfers per grant
    doReset();
    exp_seq = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("burst2_sel%0d", i), {2'b0, sel2}, {2'b0, exp_seq[i]});
      checkOutput($sformatf("burst2_valid%0d", i), {3'b0, ov2}, 4'b0001);
    end

    // Lock on channel 0 with BURST=1
    doReset();
`ifdef MUX_ARB_LOCK_EN
    lock_seq = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    lock_seq = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    applyStimulus(4'b0011, 4'b0000, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("lock_sel%0d", i), {2'b0, sel1}, {2'b0, lock_seq[i]});
    end
    applyStimulus(4'b0011, 4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("lock_release_sel", {2'b0, sel1}, {2'b0, lock_seq[3]});

    // Asynchronous reset in the middle of a stall, then restart from channel 0
    doReset();
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0);
    tick();
    checkOutput("prestall_sel", {2'b0, sel1}, 4'b0001);
    checkOutput("prestall_y", {3'b0, y1}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {3'b0, ov1}, 4'b0000);
    checkOutput("async_gnt", gnt1, 4'b0000);
    checkOutput("async_sel", {2'b0, sel1}, 4'b0000);
    checkOutput("async_y", {3'b0, y1}, 4'b0000);
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
    tick();
    checkOutput("post_rst_sel", {2'b0, sel1}, 4'b0011);
    checkOutput("post_rst_gnt", gnt1, 4'b1000);
    checkOutput("post_rst_y", {3'b0, y1}, 4'b0001);

    // ptr cleared by reset: with channels 0 and 2 requesting, 0 wins first
    doReset();
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("ptr_reset_sel", {2'b0, sel1}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
